// File: rtl/falafel_client_arbiter.sv
// falafel_client_arbiter: N-client front end for falafel_core.
// Two independent round-robin arbiters merge client alloc and free requests
// into single-entry show-ahead slots that the core pops like FIFOs. The
// issuing client of each granted alloc is queued in an in-order tag FIFO.
// Each core response is routed back to the client at the head of that FIFO
// and held until that client accepts it.
module falafel_client_arbiter #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TAG_DEPTH   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  // client request side
  input  logic [NUM_CLIENTS-1:0]        cli_req_val_i,
  input  logic [NUM_CLIENTS-1:0]        cli_req_is_free_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_req_data_i,
  output logic [NUM_CLIENTS-1:0]        cli_req_rdy_o,
  // client response side
  output logic [NUM_CLIENTS-1:0]        cli_rsp_val_o,
  output logic [DATA_W-1:0]             cli_rsp_data_o,
  input  logic [NUM_CLIENTS-1:0]        cli_rsp_rdy_i,
  // core alloc fifo interface
  output logic                          alloc_fifo_empty_o,
  input  logic                          alloc_fifo_read_i,
  output logic [DATA_W-1:0]             alloc_fifo_dout_o,
  // core free fifo interface
  output logic                          free_fifo_empty_o,
  input  logic                          free_fifo_read_i,
  output logic [DATA_W-1:0]             free_fifo_dout_o,
  // core response fifo interface
  output logic                          resp_fifo_full_o,
  input  logic                          resp_fifo_write_i,
  input  logic [DATA_W-1:0]             resp_fifo_din_i
);

  localparam int unsigned TAG_W = $clog2(NUM_CLIENTS);
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Round-robin pick: first candidate at or after ptr, wrapping.
  // Returns {found, winner index}.
  function automatic logic [TAG_W:0] rr_pick(input logic [NUM_CLIENTS-1:0] cand,
                                             input logic [TAG_W-1:0]       ptr);
    logic             found;
    logic [TAG_W-1:0] win;
    logic [TAG_W-1:0] sel;
    int unsigned      idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      sel = TAG_W'(idx);
      if (!found && cand[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
    return {found, win};
  endfunction

  // Pointer following a winner, modulo NUM_CLIENTS.
  function automatic logic [TAG_W-1:0] rr_next(input logic [TAG_W-1:0] win);
    if (win == TAG_W'(NUM_CLIENTS - 1)) return '0;
    return win + 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic                alloc_valid_q, alloc_valid_d;
  logic [DATA_W-1:0]   alloc_data_q,  alloc_data_d;
  logic                free_valid_q,  free_valid_d;
  logic [DATA_W-1:0]   free_data_q,   free_data_d;
  logic [TAG_W-1:0]    alloc_rr_q,    alloc_rr_d;
  logic [TAG_W-1:0]    free_rr_q,     free_rr_d;

  logic [TAG_W-1:0]    tag_mem_q [TAG_DEPTH];
  logic [TAG_W-1:0]    tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0]    tag_wr_q,  tag_wr_d;
  logic [PTR_W-1:0]    tag_rd_q,  tag_rd_d;
  logic [CNT_W-1:0]    tag_cnt_q, tag_cnt_d;

  logic [NUM_CLIENTS-1:0] rsp_val_q,  rsp_val_d;
  logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0]      req_data [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] alloc_cand, free_cand;
  logic [TAG_W:0]         alloc_pick, free_pick;
  logic [TAG_W-1:0]       alloc_win,  free_win;
  logic                   alloc_found, free_found;
  logic                   alloc_open,  free_open;
  logic                   alloc_grant, free_grant;
  logic                   tag_full, tag_empty;
  logic                   rsp_hold, rsp_accept, rsp_done;

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign req_data[g] = cli_req_data_i[g*DATA_W +: DATA_W];
  end

  assign tag_full   = (tag_cnt_q == CNT_W'(TAG_DEPTH));
  assign tag_empty  = (tag_cnt_q == '0);
  assign rsp_hold   = |rsp_val_q;
  assign rsp_accept = resp_fifo_write_i && !resp_fifo_full_o;
  assign rsp_done   = |(rsp_val_q & cli_rsp_rdy_i);

  // Arbitration for both request types and the resulting per-client accepts.
  always_comb begin
    alloc_cand    = cli_req_val_i & ~cli_req_is_free_i;
    free_cand     = cli_req_val_i &  cli_req_is_free_i;
    alloc_pick    = rr_pick(alloc_cand, alloc_rr_q);
    free_pick     = rr_pick(free_cand,  free_rr_q);
    alloc_found   = alloc_pick[TAG_W];
    alloc_win     = alloc_pick[TAG_W-1:0];
    free_found    = free_pick[TAG_W];
    free_win      = free_pick[TAG_W-1:0];
    alloc_open    = !alloc_valid_q || alloc_fifo_read_i;
    free_open     = !free_valid_q  || free_fifo_read_i;
    alloc_grant   = alloc_found && alloc_open && !tag_full;
    free_grant    = free_found  && free_open;
    cli_req_rdy_o = '0;
    if (alloc_grant) cli_req_rdy_o[alloc_win] = 1'b1;
    if (free_grant)  cli_req_rdy_o[free_win]  = 1'b1;
  end

  // Slot and round-robin pointer updates; a grant on a popped slot refills it.
  always_comb begin
    alloc_valid_d = alloc_valid_q;
    alloc_data_d  = alloc_data_q;
    free_valid_d  = free_valid_q;
    free_data_d   = free_data_q;
    alloc_rr_d    = alloc_rr_q;
    free_rr_d     = free_rr_q;
    if (alloc_grant) begin
      alloc_valid_d = 1'b1;
      alloc_data_d  = req_data[alloc_win];
      alloc_rr_d    = rr_next(alloc_win);
    end else if (alloc_fifo_read_i) begin
      alloc_valid_d = 1'b0;
    end
    if (free_grant) begin
      free_valid_d = 1'b1;
      free_data_d  = req_data[free_win];
      free_rr_d    = rr_next(free_win);
    end else if (free_fifo_read_i) begin
      free_valid_d = 1'b0;
    end
  end

  // Tag FIFO: push the alloc winner, pop when the core response is accepted.
  always_comb begin
    tag_mem_d = tag_mem_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    tag_cnt_d = tag_cnt_q;
    if (alloc_grant) begin
      tag_mem_d[tag_wr_q] = alloc_win;
      tag_wr_d            = tag_wr_q + 1'b1;
    end
    if (rsp_accept) tag_rd_d = tag_rd_q + 1'b1;
    case ({alloc_grant, rsp_accept})
      2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
      2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  // Response hold: load on accepted write, release after the target handshake.
  always_comb begin
    rsp_val_d  = rsp_val_q;
    rsp_data_d = rsp_data_q;
    if (rsp_accept) begin
      rsp_data_d = resp_fifo_din_i;
      for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
        rsp_val_d[k] = (tag_mem_q[tag_rd_q] == TAG_W'(k));
      end
    end else if (rsp_done) begin
      rsp_val_d = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alloc_valid_q <= 1'b0;
      alloc_data_q  <= '0;
      free_valid_q  <= 1'b0;
      free_data_q   <= '0;
      alloc_rr_q    <= '0;
      free_rr_q     <= '0;
      for (int unsigned k = 0; k < TAG_DEPTH; k++) tag_mem_q[k] <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      tag_cnt_q     <= '0;
      rsp_val_q     <= '0;
      rsp_data_q    <= '0;
    end else begin
      alloc_valid_q <= alloc_valid_d;
      alloc_data_q  <= alloc_data_d;
      free_valid_q  <= free_valid_d;
      free_data_q   <= free_data_d;
      alloc_rr_q    <= alloc_rr_d;
      free_rr_q     <= free_rr_d;
      tag_mem_q     <= tag_mem_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      tag_cnt_q     <= tag_cnt_d;
      rsp_val_q     <= rsp_val_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign alloc_fifo_empty_o = !alloc_valid_q;
  assign alloc_fifo_dout_o  = alloc_data_q;
  assign free_fifo_empty_o  = !free_valid_q;
  assign free_fifo_dout_o   = free_data_q;
  assign resp_fifo_full_o   = rsp_hold || tag_empty;
  assign cli_rsp_val_o      = rsp_val_q;
  assign cli_rsp_data_o     = rsp_data_q;

endmodule
